fb_pixel_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_bit_merge.sv | 20 ++
 rtl/fb_pixel_writer.sv | 139 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and writer state encoding.
// Imported by the pixel writer and its bit-merge helper.
package fb_pkg;

  localparam int FB_W          = 128;
  localparam int FB_H          = 128;
  localparam int BYTES_PER_ROW = FB_W / 8;
  localparam int FB_ADDR_W     = 11;
  localparam int FB_BYTES      = FB_W * FB_H / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    CLR
  } wr_state_e;

endpackage

// File: rtl/fb_bit_merge.sv
// Replaces one bit of a frame-buffer byte.
// Either forces it to a value or inverts it.
module fb_bit_merge
  import fb_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic [2:0] idx_i,
  input  logic       val_i,
  input  logic       xor_i,
  output logic [7:0] byte_o
);

  // Copy the byte, then overwrite only the addressed pixel bit
  always_comb begin
    byte_o = byte_i;
    if (xor_i) byte_o[idx_i] = ~byte_i[idx_i];
    else       byte_o[idx_i] = val_i;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write engine: pixel RMW and full-screen fill.
// FBW_XOR_EN adds pix_xor to invert the target bit.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int FB_W   = 128,
  parameter int FB_H   = 128,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [6:0]        pix_x,
  input  logic [6:0]        pix_y,
  input  logic              pix_on,
`ifdef FBW_XOR_EN
  input  logic              pix_xor,
`endif
  input  logic              clr_req,
  input  logic              clr_val,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              ram_wr_en,
  output logic [7:0]        ram_wr_data
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_W * FB_H / 8 - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              done_q, done_d;
  logic [2:0]        bit_q, bit_d;
  logic              on_q, on_d;
  logic              xor_q, xor_d;
  logic              xor_in;
  logic [7:0]        merged;

`ifdef FBW_XOR_EN
  assign xor_in = pix_xor;
`else
  assign xor_in = 1'b0;
`endif

  fb_bit_merge u_merge (
    .byte_i (ram_rd_data),
    .idx_i  (bit_q),
    .val_i  (on_q),
    .xor_i  (xor_q),
    .byte_o (merged)
  );

  // State and datapath registers; reset abandons any write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      wdat_q  <= '0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      on_q    <= 1'b0;
      xor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_en_q <= wr_en_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      on_q    <= on_d;
      xor_q   <= xor_d;
    end
  end

  // Next-state: pixel RMW sequence and linear fill sweep
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en_d = wr_en_q;
    wdat_d  = wdat_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
    on_d    = on_q;
    xor_d   = xor_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLR;
          addr_d  = '0;
          wr_en_d = 1'b1;
          wdat_d  = {8{clr_val}};
        end else if (pix_valid) begin
          state_d = RD;
          addr_d  = ADDR_W'({pix_y, pix_x[6:3]});
          bit_d   = pix_x[2:0];
          on_d    = pix_on;
          xor_d   = xor_in;
        end
      end
      RD: state_d = WAIT;
      WAIT: begin
        state_d = WR;
        wdat_d  = merged;
        wr_en_d = 1'b1;
      end
      WR: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
      CLR: begin
        if (addr_q == LAST) begin
          state_d = IDLE;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  assign pix_ready   = rst_n && (state_q == IDLE) && !clr_req;
  assign busy        = (state_q != IDLE);
  assign clr_done    = done_q;
  assign ram_addr    = addr_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_data = wdat_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer with a RAM model.
// Golden frame image predicts every write the DUT issues.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [6:0]  pix_x = '0;
  logic [6:0]  pix_y = '0;
  logic        pix_on = 1'b0;
  logic        pix_xor = 1'b0;
  logic        clr_req = 1'b0;
  logic        clr_val = 1'b0;
  logic        busy;
  logic        clr_done;
  logic [10:0] ram_addr;
  logic [7:0]  ram_rd_data;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_data;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        expq[$];
  logic [7:0] mem    [2048] = '{default: 8'h00};
  logic [7:0] golden [2048] = '{default: 8'h00};
  logic [7:0] snap   [2048];
  logic [7:0] rd_q = 8'h00;
  logic       poke_en = 1'b0;
  logic [10:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_on      (pix_on),
`ifdef FBW_XOR_EN
    .pix_xor     (pix_xor),
`endif
    .clr_req     (clr_req),
    .clr_val     (clr_val),
    .busy        (busy),
    .clr_done    (clr_done),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data)
  );

  // Synchronous RAM: registered read, write port shared with pokes
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    rd_q <= mem[ram_addr];
  end
  assign ram_rd_data = rd_q;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write
  always @(negedge clk) begin
    if (rst_n) begin
      if (clr_done) done_cnt++;
      if (ram_wr_en) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 32'(ram_addr), 32'hFFFF);
        end else begin
          wr_t e;
          e = expq.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.a));
          chk("wr_data", 32'(ram_wr_data), 32'(e.d));
        end
      end
    end
  end

  function automatic logic [7:0] ref_byte(logic [7:0] b, int n,
                                          bit on, bit xr);
    int m;
    int v;
    m = 1 << n;
    v = int'(b);
    if (xr) v = v ^ m;
    else if (on) v = v | m;
    else v = v & ~m;
    return 8'(v);
  endfunction

  task automatic poke(int a, logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_a = 11'(a);
    poke_d = d;
    golden[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_pix(int x, int y, bit on, bit xr);
    int n;
    int a;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = 7'(x);
    pix_y = 7'(y);
    pix_on = on;
    pix_xor = xr;
    n = 0;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      chk("pix_accept_timeout", 0, 1);
      pix_valid = 1'b0;
      return;
    end
    a = y * 16 + x / 8;
    golden[a] = ref_byte(golden[a], x % 8, on, xr);
    expq.push_back('{11'(a), golden[a]});
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_x = 7'($urandom);
    pix_y = 7'($urandom);
    pix_on = 1'($urandom);
    pix_xor = 1'b0;
  endtask

  // Called right after acceptance edge E0
  task automatic pix_timing(string tag);
    @(negedge clk);
    chk({tag, "_rdy_e0"}, 32'(pix_ready), 0);
    chk({tag, "_busy_e0"}, 32'(busy), 1);
    chk({tag, "_we_e0"}, 32'(ram_wr_en), 0);
    @(negedge clk);
    chk({tag, "_rdy_e1"}, 32'(pix_ready), 0);
    chk({tag, "_we_e1"}, 32'(ram_wr_en), 0);
    @(negedge clk);
    chk({tag, "_rdy_e2"}, 32'(pix_ready), 0);
    chk({tag, "_we_e2"}, 32'(ram_wr_en), 1);
    @(negedge clk);
    chk({tag, "_rdy_e3"}, 32'(pix_ready), 1);
    chk({tag, "_we_e3"}, 32'(ram_wr_en), 0);
    chk({tag, "_busy_e3"}, 32'(busy), 0);
  endtask

  function automatic void push_fill(bit v);
    for (int i = 0; i < 2048; i++) begin
      golden[i] = {8{v}};
      expq.push_back('{11'(i), {8{v}}});
    end
  endfunction

  initial begin
    int bcnt;
    int d0;
    int wcnt;
    int mism;
    #1;
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    chk("rst_wr_data", 32'(ram_wr_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(pix_ready), 1);

    do_pix(5, 0, 1'b1, 1'b0);
    pix_timing("p5_0");
    do_pix(127, 127, 1'b1, 1'b0);
    pix_timing("p127_127");
    poke(48, 8'h5A);
    poke(49, 8'hFF);
    poke(50, 8'hA5);
    do_pix(10, 3, 1'b0, 1'b0);
    pix_timing("p10_3");

    for (int i = 0; i < 40; i++) begin
      do_pix(int'($urandom_range(127)), int'($urandom_range(127)),
             1'($urandom), 1'b0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

`ifdef FBW_XOR_EN
    poke(0, 8'h01);
    do_pix(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      do_pix(int'($urandom_range(127)), int'($urandom_range(127)),
             1'($urandom), 1'($urandom));
`endif
    repeat (6) @(negedge clk);

    // Fill with ones, retrigger and flip clr_val mid-sweep
    d0 = done_cnt;
    clr_val = 1'b1;
    clr_req = 1'b1;
    push_fill(1'b1);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    bcnt = 0;
    @(negedge clk);
    while (busy && bcnt < 3000) begin
      bcnt++;
      if (bcnt == 50) clr_val = 1'b0;
      if (bcnt == 100) clr_req = 1'b1;
      if (bcnt == 101) clr_req = 1'b0;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(bcnt), 2048);
    chk("clr_done_at_end", 32'(clr_done), 1);
    @(negedge clk);
    chk("clr_done_single", 32'(clr_done), 0);
    chk("clr_done_count", 32'(done_cnt - d0), 1);

    for (int i = 0; i < 10; i++)
      do_pix(int'($urandom_range(127)), int'($urandom_range(127)),
             1'($urandom), 1'b0);
    repeat (6) @(negedge clk);

    // Clear and pixel presented together: clear first
    d0 = done_cnt;
    clr_val = 1'b0;
    clr_req = 1'b1;
    pix_valid = 1'b1;
    pix_x = 7'd33;
    pix_y = 7'd64;
    pix_on = 1'b1;
    pix_xor = 1'b0;
    #1;
    chk("tie_ready_low", 32'(pix_ready), 0);
    push_fill(1'b0);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    bcnt = 0;
    @(negedge clk);
    while (!pix_ready && bcnt < 3000) begin
      bcnt++;
      @(negedge clk);
    end
    chk("tie_wait_cycles", 32'(bcnt), 2048);
    chk("tie_done_with_ready", 32'(clr_done), 1);
    if (pix_ready) begin
      golden[64 * 16 + 4] = ref_byte(golden[64 * 16 + 4], 1, 1'b1, 1'b0);
      expq.push_back('{11'(64 * 16 + 4), golden[64 * 16 + 4]});
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("tie_done_count", 32'(done_cnt - d0), 1);

    // Reset in the middle of a ones-fill sweep
    snap = golden;
    clr_val = 1'b1;
    clr_req = 1'b1;
    push_fill(1'b1);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    bcnt = 0;
    @(negedge clk);
    while (!(busy && ram_addr == 11'd700) && bcnt < 3000) begin
      bcnt++;
      @(negedge clk);
    end
    chk("sweep_reached_700", 32'(ram_addr), 700);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_pix_ready", 32'(pix_ready), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_clr_done", 32'(clr_done), 0);
    chk("mrst_addr", 32'(ram_addr), 0);
    chk("mrst_wr_en", 32'(ram_wr_en), 0);
    chk("mrst_wr_data", 32'(ram_wr_data), 0);
    expq.delete();
    for (int i = 0; i < 2048; i++)
      golden[i] = (i < 700) ? 8'hFF : snap[i];
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_wr_en) wcnt++;
    end
    chk("no_write_after_rst", 32'(wcnt), 0);
    chk("ready_after_mrst", 32'(pix_ready), 1);

    for (int i = 0; i < 10; i++)
      do_pix(int'($urandom_range(127)), int'($urandom_range(127)),
             1'($urandom), 1'b0);
    repeat (8) @(negedge clk);

    chk("queue_drained", 32'(expq.size()), 0);
    mism = 0;
    for (int i = 0; i < 2048; i++)
      if (mem[i] !== golden[i]) mism++;
    chk("ram_image_bytes_off", 32'(mism), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
